// File: rtl/fir_pkg.sv
// Shared definitions for the FIR feeder and the FIR filter it drives.
// Holds the feeder FSM encoding, the default filter geometry and a small
// width helper used for counters and pointers.
package fir_pkg;

  localparam int unsigned DefaultTapSize   = 6;
  localparam int unsigned DefaultNbrOfTaps = 3;
  localparam int unsigned DefaultXnSize    = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StConfig = 2'd1,
    StStream = 2'd2,
    StGap    = 2'd3
  } fir_state_e;

  // Bits needed to index n entries; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_feeder_fifo.sv
// Small synchronous FIFO holding samples for the FIR feeder.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, wdata_i    write request and data (ignored when full)
//   pop_i              read request (ignored when empty)
//   rdata_o            head entry, valid whenever empty_o is low
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries
module fir_feeder_fifo #(
  parameter int unsigned  Width = 8,
  parameter int unsigned  Depth = 4,
  localparam int unsigned PtrW  = fir_pkg::cnt_width(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fir_feeder.sv
// FIR feeder: accepts host words (samples or coefficients), buffers samples
// in a FIFO and coefficients in a shadow register file, and drives either a
// coefficient load burst or a sample stream toward the FIR filter.
// Optional feature macro: FIR_FEEDER_STATS_EN adds sample_count.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   in_data, in_kind    host word and its kind (0 sample, 1 coefficient)
//   in_valid, in_ready  host handshake
//   coeff_commit        pulse requesting a coefficient load
//   x_n                 registered sample/coefficient toward the filter
//   s_axis_fir_tvalid   registered sample-stream valid
//   s_set_coeffs        registered coefficient-shift enable
//   busy                FSM not in IDLE
//   sample_count        (FIR_FEEDER_STATS_EN) saturating STREAM-cycle count
module fir_feeder
  import fir_pkg::*;
#(
  parameter int unsigned TAP_SIZE    = DefaultTapSize,
  parameter int unsigned NBR_OF_TAPS = DefaultNbrOfTaps,
  parameter int unsigned X_N_SIZE    = DefaultXnSize,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [X_N_SIZE-1:0] in_data,
  input  logic                in_kind,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                coeff_commit,
  output logic [X_N_SIZE-1:0] x_n,
  output logic                s_axis_fir_tvalid,
  output logic                s_set_coeffs,
  output logic                busy
`ifdef FIR_FEEDER_STATS_EN
  ,
  output logic [7:0]          sample_count
`endif
);

  localparam int unsigned TapIdxW  = cnt_width(NBR_OF_TAPS);
  localparam int unsigned FifoCntW = cnt_width(FIFO_DEPTH) + 1;

  fir_state_e state_q, state_d;

  logic [TapIdxW-1:0]  cnt_q, cnt_d;
  logic [TapIdxW-1:0]  wr_ptr_q, wr_ptr_d;
  logic                pending_q, pending_d;
  logic [TAP_SIZE-1:0] shadow_q [NBR_OF_TAPS];
  logic [X_N_SIZE-1:0] x_n_q, x_n_d;
  logic                tvalid_q, tvalid_d;
  logic                set_q, set_d;

  logic                coeff_we, sample_push, pop, last_pop, enter_config;
  logic                fifo_full, fifo_empty;
  logic [X_N_SIZE-1:0] fifo_rdata;
  logic [FifoCntW-1:0] fifo_count;
  logic [TAP_SIZE-1:0] tap_sel;

  // Host handshake
  assign in_ready    = in_kind ? (state_q != StConfig) : ~fifo_full;
  assign coeff_we    = in_valid & in_ready & in_kind;
  assign sample_push = in_valid & in_ready & ~in_kind;

  // A pending commit stops popping so STREAM can hand over to CONFIG.
  assign pop          = (state_q == StStream) & ~fifo_empty & ~pending_q;
  assign last_pop     = pop & (fifo_count == FifoCntW'(1)) & ~sample_push;
  assign enter_config = (state_q == StIdle) & pending_q;

  fir_feeder_fifo #(
    .Width (X_N_SIZE),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (sample_push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d = StConfig;
        end else if (!fifo_empty) begin
          state_d = StStream;
        end
      end
      StConfig: begin
        if (cnt_q == TapIdxW'(NBR_OF_TAPS - 1)) begin
          state_d = StGap;
        end
      end
      StStream: begin
        if (pending_q || fifo_empty || last_pop) begin
          state_d = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, computed one cycle ahead and registered below. Taps are
  // shifted highest index first so shadow[k] settles in filter tap k.
  always_comb begin
    x_n_d    = '0;
    tvalid_d = 1'b0;
    set_d    = 1'b0;
    tap_sel  = shadow_q[TapIdxW'(NBR_OF_TAPS - 1) - cnt_q];
    unique case (state_q)
      StConfig: begin
        set_d = 1'b1;
        x_n_d = X_N_SIZE'($signed(tap_sel));
      end
      StStream: begin
        tvalid_d = pop;
        x_n_d    = pop ? fifo_rdata : '0;
      end
      default: begin
        x_n_d    = '0;
        tvalid_d = 1'b0;
        set_d    = 1'b0;
      end
    endcase
  end

  // Datapath next state
  always_comb begin
    cnt_d     = (state_q == StConfig) ? cnt_q + TapIdxW'(1) : '0;
    pending_d = enter_config ? 1'b0 : (pending_q | coeff_commit);
    wr_ptr_d  = wr_ptr_q;
    if (coeff_we) begin
      wr_ptr_d = (wr_ptr_q == TapIdxW'(NBR_OF_TAPS - 1)) ? '0 : wr_ptr_q + TapIdxW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      pending_q <= 1'b0;
      x_n_q     <= '0;
      tvalid_q  <= 1'b0;
      set_q     <= 1'b0;
      for (int i = 0; i < int'(NBR_OF_TAPS); i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      pending_q <= pending_d;
      x_n_q     <= x_n_d;
      tvalid_q  <= tvalid_d;
      set_q     <= set_d;
      if (coeff_we) begin
        shadow_q[wr_ptr_q] <= in_data[TAP_SIZE-1:0];
      end
    end
  end

  assign x_n               = x_n_q;
  assign s_axis_fir_tvalid = tvalid_q;
  assign s_set_coeffs      = set_q;
  assign busy              = (state_q != StIdle);

`ifdef FIR_FEEDER_STATS_EN
  logic [7:0] sample_count_q, sample_count_d;

  always_comb begin
    sample_count_d = sample_count_q;
    if (enter_config) begin
      sample_count_d = '0;
    end else if ((state_q == StStream) && (sample_count_q != 8'hFF)) begin
      sample_count_d = sample_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_count_q <= '0;
    end else begin
      sample_count_q <= sample_count_d;
    end
  end

  assign sample_count = sample_count_q;
`endif

endmodule

// File: doc/fir_feeder.md
FIR_FEEDER -- requirements
Module: fir_feeder

Interface
REQ-001 Parameters SHALL be: TAP_SIZE, 6, coefficient width; NBR_OF_TAPS, 3, coefficients per load; X_N_SIZE, 8, sample width; FIFO_DEPTH, 4, sample FIFO entries (power of two).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 in_data  in  X_N_SIZE  host word: sample or coefficient.
REQ-005 in_kind  in  1  0 = sample, 1 = coefficient.
REQ-006 in_valid / in_ready  in / out  1 / 1  host handshake; word transfers on a rising edge with both high.
REQ-007 coeff_commit  in  1  one-cycle pulse requesting a coefficient load into the filter.
REQ-008 x_n  out  X_N_SIZE  signed sample or coefficient toward the filter.
REQ-009 s_axis_fir_tvalid  out  1  sample-stream valid toward the filter.
REQ-010 s_set_coeffs  out  1  coefficient-shift enable toward the filter.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Coefficient words SHALL be written to shadow[wr_ptr] (low TAP_SIZE bits); wr_ptr increments and wraps at NBR_OF_TAPS-1 to 0.
REQ-013 Sample words SHALL be pushed into a FIFO_DEPTH FIFO.
REQ-014 in_ready SHALL be: kind 1 -> high unless state is CONFIG; kind 0 -> high unless FIFO full; push and pop on the same edge leave the count unchanged.
REQ-015 coeff_commit SHALL set a sticky pending flag, cleared on entry to CONFIG; a repeat commit while pending is absorbed.
REQ-016 FSM states SHALL be IDLE, CONFIG, STREAM, GAP.
REQ-017 IDLE: pending -> CONFIG (priority); else FIFO non-empty -> STREAM; else stay.
REQ-018 CONFIG SHALL last exactly NBR_OF_TAPS cycles with s_set_coeffs=1, tvalid=0, x_n = sign-extended shadow[NBR_OF_TAPS-1-cnt], so shadow[k] ends in filter tap k; then GAP.
REQ-019 STREAM SHALL pop one sample per cycle with tvalid=1 and x_n = popped sample; exit to GAP when the FIFO becomes empty or pending is set.
REQ-020 GAP SHALL last one cycle with s_set_coeffs=0, tvalid=0, x_n=0; then IDLE.
REQ-021 s_set_coeffs and s_axis_fir_tvalid SHALL never be high together.
REQ-022 Outputs SHALL be registered; a sample accepted on edge t into an empty FIFO in IDLE appears on x_n with tvalid on edge t+2.
REQ-023 Outputs change on rising edges only, giving the filter's falling-edge sampling a half-cycle setup.
REQ-024 Shadow writes during STREAM/GAP/IDLE SHALL be legal and affect the next CONFIG only.

Reset
REQ-025 With reset_n low at a rising edge: state=IDLE, x_n=0, tvalid=0, s_set_coeffs=0, busy=0, FIFO empty, wr_ptr=0, pending=0, shadow all zero; applies mid-CONFIG/STREAM, discarding queued samples.

Configuration
REQ-026 With FIR_FEEDER_STATS_EN defined, output sample_count [7:0] SHALL count STREAM cycles, saturating at 255, cleared by reset and on each CONFIG entry; without it the port and counter SHALL not exist.

Structure
REQ-027 A shared package fir_pkg SHALL hold the FSM state encoding and the default TAP_SIZE/NBR_OF_TAPS/X_N_SIZE constants, shared with the filter.
REQ-028 The sample FIFO SHALL be a sub-module fir_feeder_fifo (push/pop, full/empty, count).

Verification
REQ-029 Write coeffs 0x01,0x3F,0x02, commit -> 3 cycles s_set_coeffs=1 with x_n = 0x02, 0xFF, 0x01, then one GAP cycle.
REQ-030 Push samples 10,20,30 -> tvalid high for exactly 3 consecutive cycles, x_n = 10,20,30, first at acceptance+2.
REQ-031 Push 5 samples back-to-back while IDLE with no pop -> 4 accepted, in_ready low on the 5th until the first pop.
REQ-032 Commit during a 4-sample stream after 2 pops -> STREAM exits, GAP, CONFIG, GAP, then remaining 2 samples stream.
REQ-033 Assert reset_n=0 mid-CONFIG -> next edge all outputs 0, FIFO empty, later commit loads all-zero shadow.
REQ-034 With FIR_FEEDER_STATS_EN, stream 300 samples -> sample_count=255.
